// File: rtl/framing_overlap_if.sv
// Sample-in / frame-out bundle for the overlapping framer.
// The slave side is the framer itself; the master side is the source plus the consumer.
interface framing_overlap_if #(
  parameter int SAMPLE_W  = 12,
  parameter int FRAME_LEN = 64
);
  logic [SAMPLE_W-1:0]                  sample_in;
  logic                                 sample_valid;
  logic [0:FRAME_LEN-1][SAMPLE_W-1:0]   frame_out;
  logic                                 frame_valid;
  logic                                 frame_ready;
  logic                                 overflow;

  modport master (
    output sample_in, sample_valid, frame_ready,
    input  frame_out, frame_valid, overflow
  );

  modport slave (
    input  sample_in, sample_valid, frame_ready,
    output frame_out, frame_valid, overflow
  );
endinterface

// File: rtl/framing_overlap.sv
// Overlapping framer: keeps the last FRAME_LEN samples in a circular history and
// emits an oldest-first frame after the prefill and then every HOP accepted samples.
module framing_overlap #(
  parameter int SAMPLE_W  = 12,
  parameter int FRAME_LEN = 64,
  parameter int HOP       = 32
) (
  input  logic             clk,
  input  logic             rst,
  framing_overlap_if.slave bus
);
  localparam int PTR_W  = $clog2(FRAME_LEN);
  localparam int FILL_W = $clog2(FRAME_LEN + 1);
  localparam int HOP_W  = $clog2(HOP + 1);
  localparam int SUM_W  = PTR_W + 2;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;
  typedef logic [0:FRAME_LEN-1][SAMPLE_W-1:0] frame_t;

  logic [SAMPLE_W-1:0] buf_r [0:FRAME_LEN-1];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [FILL_W-1:0]   fill_cnt_r;
  logic [HOP_W-1:0]    hop_cnt_r;
  state_t              state_r;
  frame_t              frame_out_r;
  frame_t              frame_s;
  logic                frame_valid_r;
  logic                overflow_r;
  logic                frame_due_s;
  logic                xfer_s;

  // Buffer slot holding frame position k, counted from the slot after the current write.
  function automatic logic [PTR_W-1:0] rd_idx(input logic [PTR_W-1:0] wp, input int k);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(wp) + SUM_W'(k + 1);
    if (sum >= SUM_W'(FRAME_LEN)) begin
      rd_idx = PTR_W'(sum - SUM_W'(FRAME_LEN));
    end else begin
      rd_idx = sum[PTR_W-1:0];
    end
  endfunction

  // Frame-due decode and output handshake.
  always_comb begin
    frame_due_s = 1'b0;
    if (bus.sample_valid) begin
      case (state_r)
        FILL:    frame_due_s = (fill_cnt_r == FILL_W'(FRAME_LEN - 1));
        RUN:     frame_due_s = (hop_cnt_r == HOP_W'(HOP - 1));
        default: frame_due_s = 1'b0;
      endcase
    end else begin
      frame_due_s = 1'b0;
    end
    xfer_s = frame_valid_r & bus.frame_ready;
  end

  // Oldest-first frame assembly; the triggering sample bypasses the buffer.
  always_comb begin
    frame_s = '0;
    for (int k = 0; k < FRAME_LEN - 1; k++) begin
      frame_s[k] = buf_r[rd_idx(wr_ptr_r, k)];
    end
    frame_s[FRAME_LEN-1] = bus.sample_in;
  end

  // Circular history write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        buf_r[i] <= '0;
      end
      wr_ptr_r <= '0;
    end else if (bus.sample_valid) begin
      buf_r[wr_ptr_r] <= bus.sample_in;
      wr_ptr_r        <= (wr_ptr_r == PTR_W'(FRAME_LEN - 1)) ? '0 : wr_ptr_r + PTR_W'(1);
    end
  end

  // Fill/hop sequencing and the registered frame output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= FILL;
      fill_cnt_r    <= '0;
      hop_cnt_r     <= '0;
      frame_out_r   <= '0;
      frame_valid_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      overflow_r <= 1'b0;
      if (bus.sample_valid) begin
        case (state_r)
          FILL: begin
            fill_cnt_r <= fill_cnt_r + FILL_W'(1);
            if (frame_due_s) begin
              state_r   <= RUN;
              hop_cnt_r <= '0;
            end
          end
          RUN: hop_cnt_r <= frame_due_s ? '0 : hop_cnt_r + HOP_W'(1);
          default: state_r <= FILL;
        endcase
      end
      // A due frame that cannot be loaded is dropped; the hop cadence is unaffected.
      if (frame_due_s) begin
        if (!frame_valid_r || xfer_s) begin
          frame_out_r   <= frame_s;
          frame_valid_r <= 1'b1;
        end else begin
          overflow_r <= 1'b1;
        end
      end else if (xfer_s) begin
        frame_valid_r <= 1'b0;
      end
    end
  end

  assign bus.frame_out   = frame_out_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.overflow    = overflow_r;
endmodule

// File: tb/tb_framing_overlap.sv
// Scoreboard bench for framing_overlap: a 64/32 instance and a 16/16 wide-sample instance.
module tb_framing_overlap;
  localparam int WA = 12, LA = 64, HA = 32;
  localparam int WB = 16, LB = 16, HB = 16;
  typedef logic [0:LA-1][WA-1:0] frame_a_t;
  typedef logic [0:LB-1][WB-1:0] frame_b_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  framing_overlap_if #(.SAMPLE_W(WA), .FRAME_LEN(LA)) a_if ();
  framing_overlap_if #(.SAMPLE_W(WB), .FRAME_LEN(LB)) b_if ();

  framing_overlap #(.SAMPLE_W(WA), .FRAME_LEN(LA), .HOP(HA)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  framing_overlap #(.SAMPLE_W(WB), .FRAME_LEN(LB), .HOP(HB)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  int total = 0;
  int bad   = 0;
  frame_a_t q_a[$];
  frame_b_t q_b[$];
  logic [WA-1:0] hist_a[$];
  logic [WB-1:0] hist_b[$];
  int n_a, n_b;
  bit mv_a, mv_b;
  int ovf_exp_a = 0, ovf_exp_b = 0;
  int ovf_seen_a = 0, ovf_seen_b = 0;

  task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented frame must match the scoreboard head; pop on transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_if.overflow) ovf_seen_a++;
      if (b_if.overflow) ovf_seen_b++;
      if (a_if.frame_valid) begin
        check("a_frame_expected", (q_a.size() != 0), 1'b1);
        if (q_a.size() != 0) begin
          check("a_frame_data", a_if.frame_out, q_a[0]);
          if (a_if.frame_ready) void'(q_a.pop_front());
        end
      end
      if (b_if.frame_valid) begin
        check("b_frame_expected", (q_b.size() != 0), 1'b1);
        if (q_b.size() != 0) begin
          check("b_frame_data", b_if.frame_out, q_b[0]);
          if (b_if.frame_ready) void'(q_b.pop_front());
        end
      end
    end
  end

  task automatic reset_dut(input int cycles);
    a_if.sample_valid = 1'b0; a_if.sample_in = '0; a_if.frame_ready = 1'b0;
    b_if.sample_valid = 1'b0; b_if.sample_in = '0; b_if.frame_ready = 1'b0;
    rst = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
    rst = 1'b0;
    hist_a.delete(); hist_b.delete(); q_a.delete(); q_b.delete();
    n_a = 0; n_b = 0; mv_a = 1'b0; mv_b = 1'b0;
  endtask

  task automatic issue_a(input bit v, input int val, input bit rdy);
    bit due, xfer;
    frame_a_t f;
    a_if.sample_valid = v; a_if.sample_in = WA'(val); a_if.frame_ready = rdy;
    xfer = mv_a && rdy;
    due  = 1'b0;
    if (v) begin
      hist_a.push_back(WA'(val));
      if (hist_a.size() > LA) void'(hist_a.pop_front());
      n_a++;
      due = (n_a == LA) || (n_a > LA && ((n_a - LA) % HA) == 0);
    end
    if (due) begin
      if (!mv_a || xfer) begin
        for (int k = 0; k < LA; k++) f[k] = hist_a[k];
        q_a.push_back(f);
        mv_a = 1'b1;
      end else begin
        ovf_exp_a++;
      end
    end else if (xfer) begin
      mv_a = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic issue_b(input bit v, input int val, input bit rdy);
    bit due, xfer;
    frame_b_t f;
    b_if.sample_valid = v; b_if.sample_in = WB'(val); b_if.frame_ready = rdy;
    xfer = mv_b && rdy;
    due  = 1'b0;
    if (v) begin
      hist_b.push_back(WB'(val));
      if (hist_b.size() > LB) void'(hist_b.pop_front());
      n_b++;
      due = (n_b == LB) || (n_b > LB && ((n_b - LB) % HB) == 0);
    end
    if (due) begin
      if (!mv_b || xfer) begin
        for (int k = 0; k < LB; k++) f[k] = hist_b[k];
        q_b.push_back(f);
        mv_b = 1'b1;
      end else begin
        ovf_exp_b++;
      end
    end else if (xfer) begin
      mv_b = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain_a(input string tag);
    repeat (4) issue_a(1'b0, 0, 1'b1);
    check({tag, "_a_queue_empty"}, q_a.size(), 0);
    check({tag, "_a_ovf_total"}, ovf_seen_a, ovf_exp_a);
  endtask

  task automatic drain_b(input string tag);
    repeat (4) issue_b(1'b0, 0, 1'b1);
    check({tag, "_b_queue_empty"}, q_b.size(), 0);
    check({tag, "_b_ovf_total"}, ovf_seen_b, ovf_exp_b);
  endtask

  initial begin
    int s;
    // Reset state and continuous prefill/hop.
    reset_dut(2);
    check("reset_valid", a_if.frame_valid, 1'b0);
    check("reset_ovf", a_if.overflow, 1'b0);
    check("reset_frame", a_if.frame_out, '0);
    for (int i = 0; i < 128; i++) begin
      issue_a(1'b1, i, 1'b1);
      if (i == 62) check("p1_valid_early", a_if.frame_valid, 1'b0);
      if (i == 63) begin
        check("p1_valid_rise", a_if.frame_valid, 1'b1);
        check("p1_oldest", a_if.frame_out[0], 12'd0);
        check("p1_newest", a_if.frame_out[63], 12'd63);
      end
      if (i == 95) check("p1_f2_oldest", a_if.frame_out[0], 12'd32);
      if (i == 127) check("p1_f3_oldest", a_if.frame_out[0], 12'd64);
    end
    drain_a("p1");

    // Gapped input with junk on idle cycles.
    reset_dut(2);
    for (int i = 0; i < 128; i++) begin
      issue_a(1'b1, i, 1'b1);
      issue_a(1'b0, 'hABC, 1'b1);
    end
    drain_a("p2");

    // Backpressure: frame 2 dropped, frame 3 loaded after release.
    reset_dut(2);
    s = ovf_seen_a;
    for (int i = 0; i < 128; i++) begin
      issue_a(1'b1, i, (i >= 100));
      if (i == 95) begin
        check("p3_ovf_pulse", a_if.overflow, 1'b1);
        check("p3_held_oldest", a_if.frame_out[0], 12'd0);
        check("p3_held_newest", a_if.frame_out[63], 12'd63);
      end
      if (i == 96) check("p3_ovf_one_cycle", a_if.overflow, 1'b0);
      if (i == 100) check("p3_valid_drop", a_if.frame_valid, 1'b0);
    end
    drain_a("p3");
    check("p3_ovf_count", ovf_seen_a - s, 1);

    // Transfer on the same cycle frame 2 falls due.
    reset_dut(2);
    s = ovf_seen_a;
    for (int i = 0; i < 96; i++) issue_a(1'b1, i, (i == 95));
    check("p4_valid_kept", a_if.frame_valid, 1'b1);
    check("p4_no_ovf", a_if.overflow, 1'b0);
    check("p4_f2_oldest", a_if.frame_out[0], 12'd32);
    drain_a("p4");
    check("p4_ovf_count", ovf_seen_a - s, 0);

    // Reset with a pending frame, then a full prefill again.
    reset_dut(2);
    s = ovf_seen_a;
    for (int i = 0; i <= 80; i++) issue_a(1'b1, i, 1'b0);
    reset_dut(1);
    check("p5_valid_cleared", a_if.frame_valid, 1'b0);
    check("p5_ovf_cleared", a_if.overflow, 1'b0);
    check("p5_frame_cleared", a_if.frame_out, '0);
    for (int j = 0; j < 64; j++) begin
      issue_a(1'b1, 200 + j, 1'b1);
      if (j == 62) check("p5_no_early_frame", a_if.frame_valid, 1'b0);
      if (j == 63) begin
        check("p5_valid_after_prefill", a_if.frame_valid, 1'b1);
        check("p5_oldest", a_if.frame_out[0], 12'd200);
      end
    end
    drain_a("p5");
    check("p5_ovf_count", ovf_seen_a - s, 0);

    // Non-overlapping 16/16 framing and full-width samples.
    reset_dut(2);
    for (int i = 0; i < 32; i++) begin
      issue_b(1'b1, 100 + i, 1'b1);
      if (i == 15) begin
        check("p6_oldest", b_if.frame_out[0], 16'd100);
        check("p6_newest", b_if.frame_out[15], 16'd115);
      end
      if (i == 31) check("p6_f2_oldest", b_if.frame_out[0], 16'd116);
    end
    for (int i = 0; i < 16; i++) issue_b(1'b1, 'hFFFF, 1'b1);
    check("p6_wide_oldest", b_if.frame_out[0], 16'hFFFF);
    check("p6_wide_newest", b_if.frame_out[15], 16'hFFFF);
    drain_b("p6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
